jpu_uart_tx: RTL

Buffered UART transmitter that serialises bytes produced by the JPU core onto the board-level `uart_rxd_out` pin. It sits inside `jpu_impl`, directly upstream of that top-level output. The core pushes bytes through a valid/ready handshake into a small FIFO. An 8N1 shifter drains the FIFO at a fixed baud rate, and consecutive frames go out back-to-back.

---
 rtl/jpu_uart_pkg.sv | 15 +
 rtl/jpu_uart_tx_if.sv | 12 +
 rtl/jpu_sync_fifo.sv | 53 +++++
 rtl/jpu_uart_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/jpu_uart_pkg.sv
// Shared types and constants for the JPU UART blocks.
//   uart_tx_state_e : frame FSM states (transmitter now, receiver later)
//   UART_FRAME_BITS : bit periods per 8N1 frame (start + 8 data + stop)
package jpu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/jpu_uart_tx_if.sv
// Byte handshake between the JPU core and the UART transmitter.
//   tx_data  : byte to send (producer -> transmitter)
//   tx_valid : tx_data is valid (producer -> transmitter)
//   tx_ready : transmitter can take a byte (transmitter -> producer)
interface jpu_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/jpu_sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count.
//   clk, rst : clock, synchronous active-high reset
//   i_push   : write i_data (caller guarantees not full)
//   i_pop    : drop head entry (caller guarantees not empty)
//   o_data   : current head entry
//   o_count  : occupancy, 0..DEPTH
module jpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of 2, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/jpu_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO via valid/ready and are
// serialised LSB first onto uart_rxd_out, frames back-to-back.
//   clk, rst     : clock, synchronous active-high reset
//   tx_if        : byte handshake (slave side)
//   uart_rxd_out : serial line, idle high, driven from a flop
//   busy         : frame in progress or FIFO non-empty
//   fifo_count   : FIFO occupancy
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (line high); pops the next byte straight into START
module jpu_uart_tx
    import jpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    jpu_uart_tx_if.slave                tx_if,
    output logic                        uart_rxd_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("jpu_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("jpu_uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    uart_tx_state_e r_state;
    logic [BW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic           r_line;

    logic [7:0]     w_head;
    logic [CW-1:0]  w_count;
    logic           w_push;
    logic           w_pop;
    logic           w_nonempty;
    logic           w_bit_end;

    assign w_nonempty = (w_count != '0);
    assign w_bit_end  = (r_cnt == BW'(CLKS_PER_BIT - 1));
    assign w_push     = tx_if.tx_valid && tx_if.tx_ready;
    assign w_pop      = w_nonempty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    jpu_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (tx_if.tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // r_line is loaded with the value of the upcoming bit at each transition,
    // so the pin is registered and tracks the state with no extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_line <= 1'b1;
                    if (w_nonempty) begin
                        r_shift <= w_head;
                        r_state <= START;
                        r_line  <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= DATA;
                        r_line  <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                            r_line  <= 1'b1;
                        end else begin
                            r_line  <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_nonempty) begin
                            r_shift <= w_head;
                            r_state <= START;
                            r_line  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_line  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

    // Decoded from the registered count: a pop frees space one cycle later.
    assign tx_if.tx_ready = (w_count != CW'(FIFO_DEPTH));
    assign uart_rxd_out   = r_line;
    assign busy           = (r_state != IDLE) || w_nonempty;
    assign fifo_count     = w_count;

endmodule
